// File: rtl/gpr_rs3_port_arbiter.sv
// gpr_rs3_port_arbiter
// Shares one GPR bank rs3 read port between the issue operand path and the
// tensor-core register-file request path. One grant per cycle; tensor wins
// conflicts until it has taken MAX_TC_BURST consecutive grants while issue
// waited, then issue is served. RAM data comes back one cycle after the
// read. Issue data is passed straight through. Tensor data lands in a
// 2-entry response buffer that is protected by a credit check at grant time.
//
// Handshake semantics: a transfer happens on a cycle where valid & ready are
// both high. A requester holds valid/addr until it sees ready. On the tensor
// response side, tc_rsp_valid never depends on tc_rsp_ready, and head data
// stays stable until the entry is popped.
module gpr_rs3_port_arbiter #(
    parameter int RAM_ADDRW     = 6,
    parameter int NUM_THREADS   = 4,
    parameter int XLEN          = 32,
    parameter int MAX_TC_BURST  = 4,
    parameter int PERF_CTR_BITS = 44
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            iss_req_valid,
    input  logic [RAM_ADDRW-1:0]            iss_req_addr,
    input  logic                            iss_space,
    output logic                            iss_req_ready,
    output logic                            iss_rsp_valid,
    output logic [NUM_THREADS*XLEN-1:0]     iss_rsp_data,
    input  logic                            tc_req_valid,
    input  logic [RAM_ADDRW-1:0]            tc_req_addr,
    output logic                            tc_req_ready,
    output logic                            tc_rsp_valid,
    input  logic                            tc_rsp_ready,
    output logic [NUM_THREADS*XLEN-1:0]     tc_rsp_data,
    output logic                            ram_rd_en,
    output logic [RAM_ADDRW-1:0]            ram_rd_addr,
    input  logic [NUM_THREADS*XLEN-1:0]     ram_rd_data,
    output logic [PERF_CTR_BITS-1:0]        perf_iss_stall
);

    localparam int DW = NUM_THREADS * XLEN;
    // Keep the starve counter at least one bit wide so MAX_TC_BURST=0 still elaborates.
    localparam int SW = (MAX_TC_BURST > 0) ? $clog2(MAX_TC_BURST + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_TC_BURST);

    // Combinational arbitration signals
    logic          iss_elig;
    logic          tc_elig;
    logic          grant_iss;
    logic          grant_tc;
    logic          tc_push;
    logic          tc_pop;
    logic [2:0]    credits_used;

    // State
    logic [SW-1:0]            starve_cnt_q, starve_cnt_d;
    logic                     iss_rsp_valid_q, iss_rsp_valid_d;
    logic                     tc_inflight_q, tc_inflight_d;
    logic [1:0]               buf_count_q, buf_count_d;
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic [DW-1:0]            buf_data_q [2];
    logic [DW-1:0]            buf_data_d [2];
    logic [PERF_CTR_BITS-1:0] perf_q, perf_d;

    assign tc_push = tc_inflight_q;
    assign tc_pop  = (buf_count_q != 2'd0) && tc_rsp_ready;

    // Credits held = buffered entries + the read in flight. An entry leaving
    // the buffer this cycle frees its credit immediately, which is what lets
    // a 1-per-cycle tensor stream run while the consumer keeps up.
    assign credits_used = {1'b0, buf_count_q} + {2'b00, tc_inflight_q} - {2'b00, tc_pop};

    // Eligibility and single-winner grant; no grants while reset is held
    always_comb begin
        iss_elig  = iss_req_valid && iss_space;
        tc_elig   = tc_req_valid && (credits_used < 3'd2);
        grant_iss = 1'b0;
        grant_tc  = 1'b0;
        if (!reset) begin
            if (iss_elig && tc_elig) begin
                if (starve_cnt_q == STARVE_MAX) begin
                    grant_iss = 1'b1;
                end else begin
                    grant_tc = 1'b1;
                end
            end else begin
                grant_iss = iss_elig;
                grant_tc  = tc_elig;
            end
        end
    end

    assign iss_req_ready  = grant_iss;
    assign tc_req_ready   = grant_tc;
    assign ram_rd_en      = grant_iss || grant_tc;
    assign ram_rd_addr    = grant_tc ? tc_req_addr : iss_req_addr;
    assign iss_rsp_valid  = iss_rsp_valid_q;
    assign iss_rsp_data   = ram_rd_data;
    assign tc_rsp_valid   = (buf_count_q != 2'd0);
    assign tc_rsp_data    = buf_data_q[rd_ptr_q];
    assign perf_iss_stall = perf_q;

    // Next-state: starve counter, response tracking, buffer pointers, perf counter
    always_comb begin
        starve_cnt_d    = starve_cnt_q;
        iss_rsp_valid_d = grant_iss;
        tc_inflight_d   = grant_tc;
        buf_count_d     = buf_count_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        buf_data_d      = buf_data_q;
        perf_d          = perf_q;

        if (grant_iss || !iss_elig) begin
            starve_cnt_d = '0;
        end else if (grant_tc && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end

        if (tc_push) begin
            buf_data_d[wr_ptr_q] = ram_rd_data;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (tc_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({tc_push, tc_pop})
            2'b10:   buf_count_d = buf_count_q + 2'd1;
            2'b01:   buf_count_d = buf_count_q - 2'd1;
            default: buf_count_d = buf_count_q;
        endcase

        if (iss_elig && !grant_iss && (perf_q != {PERF_CTR_BITS{1'b1}})) begin
            perf_d = perf_q + {{(PERF_CTR_BITS-1){1'b0}}, 1'b1};
        end
    end

    // Control state; reset drops in-flight reads and buffered responses
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q    <= '0;
            iss_rsp_valid_q <= 1'b0;
            tc_inflight_q   <= 1'b0;
            buf_count_q     <= 2'd0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            perf_q          <= '0;
        end else begin
            starve_cnt_q    <= starve_cnt_d;
            iss_rsp_valid_q <= iss_rsp_valid_d;
            tc_inflight_q   <= tc_inflight_d;
            buf_count_q     <= buf_count_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            perf_q          <= perf_d;
        end
    end

    // Response buffer storage; contents are meaningless until counted valid
    always_ff @(posedge clk) begin
        buf_data_q <= buf_data_d;
    end

    // The grant-time credit check must make a push into a full buffer impossible
    always_ff @(posedge clk) begin
        if (!reset && tc_push && !tc_pop) begin
            assert (buf_count_q != 2'd2);
        end
    end

endmodule
